mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 6, meaning multiply latency in clk1 cycles (issue to result).
REQ-002 SHALL have parameter DIV_LAT, default 8, meaning divide latency in clk1 cycles (issue to result).
REQ-003 clk1  input  1  sole clock; all state updates on posedge clk1.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rs_ready  input  3  bit i = mul/div reservation-station entry i valid with both operands available.
REQ-006 rs_func  input  12  entry i func at bits [4i+3:4i]; 4'b0010 = MUL, 4'b0011 = DIV.
REQ-007 rs_rob  input  9  entry i ROB index at bits [3i+2:3i].
REQ-008 rs_rd  input  12  entry i destination register at bits [4i+3:4i].
REQ-009 cdb_grant  input  1  common data bus accepts the pending result this cycle.
REQ-010 issue_valid  output  1  one-cycle pulse; selected entry dispatched to the mul/div execution unit.
REQ-011 issue_index  output  2  RS entry being executed (0..2).
REQ-012 ex_b  output  1  execution-unit busy; high in EXEC and WB.
REQ-013 done_valid  output  1  result pending broadcast; high throughout WB.
REQ-014 done_rob  output  3  ROB index of the in-flight operation.
REQ-015 done_rd  output  4  destination register of the in-flight operation.
REQ-016 rs_free_valid  output  1  one-cycle pulse; RS entry rs_free_index may be released.
REQ-017 rs_free_index  output  2  RS entry to release.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, WB.
REQ-019 Eligibility: entry i eligible iff rs_ready[i]=1 and func is MUL or DIV; any other func is never selected.
REQ-020 In IDLE, when rs_free_valid=1, entry rs_free_index SHALL be ineligible that cycle.
REQ-021 IDLE, >=1 eligible entry: select the first eligible entry scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); latch its index, rob, rd, func; load counter = latency-1 (MUL_LAT or DIV_LAT); next state EXEC; issue_valid=1 in the first EXEC cycle only.
REQ-022 IDLE, no eligible entry: remain in IDLE; outputs unchanged except pulses, which go low.
REQ-023 EXEC: counter decrements each cycle; when counter=0, next state WB.
REQ-024 done_valid SHALL first assert exactly LAT cycles after the issue_valid cycle (MUL: 6, DIV: 8 at defaults).
REQ-025 WB: hold done_valid, done_rob, done_rd stable until cdb_grant=1; cdb_grant outside WB is ignored.
REQ-026 WB with cdb_grant=1: next state IDLE; rs_free_valid=1 with rs_free_index = latched index for one cycle; rr_ptr = (latched index + 1) mod 3.
REQ-027 SHALL NOT issue in the same cycle as a grant; earliest new issue_valid is 2 cycles after the grant cycle.
REQ-028 Only one operation in flight; rs_ready changes during EXEC/WB SHALL NOT affect latched outputs.
REQ-029 rr_ptr wraps 2 -> 0.

Reset
REQ-030 On rst=1 at posedge clk1: state IDLE, rr_ptr=0, counter=0, all outputs 0.
REQ-031 rst during EXEC or WB SHALL abort the operation with no done_valid and no rs_free_valid.
REQ-032 rst overrides all other inputs in the same cycle.

Verification
REQ-033 rs_ready=001, entry0 MUL, rob=5, rd=3 -> issue_valid cycle T, issue_index=0; done_valid at T+6, done_rob=5, done_rd=3; cdb_grant at T+6 -> rs_free_valid=1, rs_free_index=0 at T+7.
REQ-034 Entry1 DIV, cdb_grant held low 4 cycles after done -> done_valid first at T+8, held with stable rob/rd until grant; ex_b high throughout.
REQ-035 rs_ready=111, all MUL, ready held, grant immediate -> issue order 0,1,2,0 (round-robin); freed entry never re-issued in the rs_free_valid cycle.
REQ-036 rs_ready=001, entry0 func=4'b0000 -> no issue_valid, FSM stays IDLE, ex_b=0.
REQ-037 rst asserted at T+3 of a MUL -> next cycle all outputs 0, no done_valid/rs_free_valid; new request afterwards issues from entry 0 priority.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Mul/div issue controller: picks one ready multiply/divide reservation-station
// entry round-robin, tracks it through a fixed-latency execution unit, holds
// the result for the common data bus and releases the RS entry once granted.
// Only one operation is ever in flight.
module mul_issue_ctrl #(
    parameter int MUL_LAT = 6,
    parameter int DIV_LAT = 8
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic [2:0]  rs_ready,
    input  logic [11:0] rs_func,
    input  logic [8:0]  rs_rob,
    input  logic [11:0] rs_rd,
    input  logic        cdb_grant,
    output logic        issue_valid,
    output logic [1:0]  issue_index,
    output logic        ex_b,
    output logic        done_valid,
    output logic [2:0]  done_rob,
    output logic [3:0]  done_rd,
    output logic        rs_free_valid,
    output logic [1:0]  rs_free_index
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_muldiv(input logic [3:0] func);
        logic hit;
        if ((func == FUNC_MUL) || (func == FUNC_DIV)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Next round-robin position; index 3 never occurs but folds back to 0.
    function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Returns {found, index}: first set bit of mask scanning ptr, ptr+1, ptr+2 mod 3.
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
        logic [3:0] mask_ext;
        logic [1:0] idx;
        logic [2:0] res;
        mask_ext = {1'b0, mask};
        idx      = ptr;
        res      = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (!res[2] && mask_ext[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
            idx = inc_mod3(idx);
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t            state_r, state_s;
    logic [1:0]        rr_ptr_r, rr_ptr_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              issue_valid_r, issue_valid_s;
    logic [1:0]        issue_index_r, issue_index_s;
    logic              ex_b_r, ex_b_s;
    logic              done_valid_r, done_valid_s;
    logic [2:0]        done_rob_r, done_rob_s;
    logic [3:0]        done_rd_r, done_rd_s;
    logic              rs_free_valid_r, rs_free_valid_s;
    logic [1:0]        rs_free_index_r, rs_free_index_s;

    logic [2:0]        elig_s;
    logic [2:0]        pick_s;
    logic [3:0]        sel_func_s;
    logic [2:0]        sel_rob_s;
    logic [3:0]        sel_rd_s;

    // Eligible entries: ready, a mul/div op, and not the entry being released this cycle.
    always_comb begin
        elig_s    = 3'b000;
        elig_s[0] = rs_ready[0] && is_muldiv(rs_func[3:0])
                    && !(rs_free_valid_r && (rs_free_index_r == 2'd0));
        elig_s[1] = rs_ready[1] && is_muldiv(rs_func[7:4])
                    && !(rs_free_valid_r && (rs_free_index_r == 2'd1));
        elig_s[2] = rs_ready[2] && is_muldiv(rs_func[11:8])
                    && !(rs_free_valid_r && (rs_free_index_r == 2'd2));
    end

    // Round-robin selection and operand-field mux for the selected entry.
    always_comb begin
        pick_s     = rr_pick(elig_s, rr_ptr_r);
        sel_func_s = 4'b0000;
        sel_rob_s  = 3'b000;
        sel_rd_s   = 4'b0000;
        case (pick_s[1:0])
            2'd0: begin
                sel_func_s = rs_func[3:0];
                sel_rob_s  = rs_rob[2:0];
                sel_rd_s   = rs_rd[3:0];
            end
            2'd1: begin
                sel_func_s = rs_func[7:4];
                sel_rob_s  = rs_rob[5:3];
                sel_rd_s   = rs_rd[7:4];
            end
            2'd2: begin
                sel_func_s = rs_func[11:8];
                sel_rob_s  = rs_rob[8:6];
                sel_rd_s   = rs_rd[11:8];
            end
            default: begin
                sel_func_s = 4'b0000;
                sel_rob_s  = 3'b000;
                sel_rd_s   = 4'b0000;
            end
        endcase
    end

    // FSM next state and next values of every registered output.
    always_comb begin
        state_s         = state_r;
        rr_ptr_s        = rr_ptr_r;
        cnt_s           = cnt_r;
        issue_valid_s   = 1'b0;
        issue_index_s   = issue_index_r;
        ex_b_s          = ex_b_r;
        done_valid_s    = done_valid_r;
        done_rob_s      = done_rob_r;
        done_rd_s       = done_rd_r;
        rs_free_valid_s = 1'b0;
        rs_free_index_s = rs_free_index_r;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    state_s       = EXEC;
                    issue_valid_s = 1'b1;
                    issue_index_s = pick_s[1:0];
                    done_rob_s    = sel_rob_s;
                    done_rd_s     = sel_rd_s;
                    ex_b_s        = 1'b1;
                    if (sel_func_s == FUNC_DIV) begin
                        cnt_s = DIV_LOAD;
                    end else begin
                        cnt_s = MUL_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s      = WB;
                    done_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            WB: begin
                if (cdb_grant) begin
                    state_s         = IDLE;
                    done_valid_s    = 1'b0;
                    ex_b_s          = 1'b0;
                    rs_free_valid_s = 1'b1;
                    rs_free_index_s = issue_index_r;
                    rr_ptr_s        = inc_mod3(issue_index_r);
                end else begin
                    state_s = WB;
                end
            end
            default: begin
                state_s      = IDLE;
                ex_b_s       = 1'b0;
                done_valid_s = 1'b0;
            end
        endcase
    end

    // FSM state register; reset returns to IDLE and aborts any in-flight op.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; reset clears everything, including the pointer.
    always_ff @(posedge clk1) begin
        if (rst) begin
            rr_ptr_r        <= 2'd0;
            cnt_r           <= CNT_ZERO;
            issue_valid_r   <= 1'b0;
            issue_index_r   <= 2'd0;
            ex_b_r          <= 1'b0;
            done_valid_r    <= 1'b0;
            done_rob_r      <= 3'd0;
            done_rd_r       <= 4'd0;
            rs_free_valid_r <= 1'b0;
            rs_free_index_r <= 2'd0;
        end else begin
            rr_ptr_r        <= rr_ptr_s;
            cnt_r           <= cnt_s;
            issue_valid_r   <= issue_valid_s;
            issue_index_r   <= issue_index_s;
            ex_b_r          <= ex_b_s;
            done_valid_r    <= done_valid_s;
            done_rob_r      <= done_rob_s;
            done_rd_r       <= done_rd_s;
            rs_free_valid_r <= rs_free_valid_s;
            rs_free_index_r <= rs_free_index_s;
        end
    end

    assign issue_valid   = issue_valid_r;
    assign issue_index   = issue_index_r;
    assign ex_b          = ex_b_r;
    assign done_valid    = done_valid_r;
    assign done_rob      = done_rob_r;
    assign done_rd       = done_rd_r;
    assign rs_free_valid = rs_free_valid_r;
    assign rs_free_index = rs_free_index_r;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a scoreboard of expected issues,
// results and releases; a negedge monitor pops and compares.
module tb_mul_issue_ctrl;

    logic        clk1 = 1'b0;
    logic        rst;
    logic [2:0]  rs_ready;
    logic [11:0] rs_func;
    logic [8:0]  rs_rob;
    logic [11:0] rs_rd;
    logic        cdb_grant;
    logic        issue_valid;
    logic [1:0]  issue_index;
    logic        ex_b;
    logic        done_valid;
    logic [2:0]  done_rob;
    logic [3:0]  done_rd;
    logic        rs_free_valid;
    logic [1:0]  rs_free_index;

    mul_issue_ctrl #(.MUL_LAT(6), .DIV_LAT(8)) dut (
        .clk1          (clk1),
        .rst           (rst),
        .rs_ready      (rs_ready),
        .rs_func       (rs_func),
        .rs_rob        (rs_rob),
        .rs_rd         (rs_rd),
        .cdb_grant     (cdb_grant),
        .issue_valid   (issue_valid),
        .issue_index   (issue_index),
        .ex_b          (ex_b),
        .done_valid    (done_valid),
        .done_rob      (done_rob),
        .done_rd       (done_rd),
        .rs_free_valid (rs_free_valid),
        .rs_free_index (rs_free_index)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] idx;
        logic [2:0] rob;
        logic [3:0] rd;
        int         lat;
    } iss_t;

    typedef struct {
        logic [2:0] rob;
        logic [3:0] rd;
        int         at;
    } done_t;

    iss_t       exp_iss[$];
    done_t      exp_done[$];
    logic [1:0] exp_free[$];
    iss_t       mi;
    done_t      md;
    logic [1:0] mf;
    logic [1:0] ord [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    int n_vec   = 0;
    int n_err   = 0;
    int n_issue = 0;
    int n0      = 0;
    logic       prev_done = 1'b0;
    logic [2:0] hold_rob  = 3'd0;
    logic [3:0] hold_rd   = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic wait_issue();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk1);
            if (issue_valid === 1'b1) break;
        end
        chk("issue_wait", issue_valid, 32'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk1);
            if (done_valid === 1'b1) break;
        end
        chk("done_wait", done_valid, 32'd1);
    endtask

    task automatic grant(input bit drop_ready);
        cdb_grant = 1'b1;
        if (drop_ready) rs_ready = 3'b000;
        @(negedge clk1);
        cdb_grant = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue_valid"}, issue_valid, 32'd0);
        chk({tag, "_issue_index"}, issue_index, 32'd0);
        chk({tag, "_ex_b"}, ex_b, 32'd0);
        chk({tag, "_done_valid"}, done_valid, 32'd0);
        chk({tag, "_done_rob"}, done_rob, 32'd0);
        chk({tag, "_done_rd"}, done_rd, 32'd0);
        chk({tag, "_free_valid"}, rs_free_valid, 32'd0);
        chk({tag, "_free_index"}, rs_free_index, 32'd0);
    endtask

    // Scoreboard monitor: compares DUT events against queued expectations.
    always @(negedge clk1) begin
        if (rst !== 1'b1) begin
            if (issue_valid === 1'b1) begin
                n_issue++;
                if (exp_iss.size() == 0) begin
                    chk("issue_unexpected", issue_valid, 32'd0);
                end else begin
                    mi = exp_iss.pop_front();
                    chk("issue_index", issue_index, mi.idx);
                    chk("issue_ex_b", ex_b, 32'd1);
                    exp_done.push_back('{mi.rob, mi.rd, cyc + mi.lat});
                end
            end
            if ((done_valid === 1'b1) && !prev_done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", done_valid, 32'd0);
                end else begin
                    md = exp_done.pop_front();
                    chk("done_cycle", cyc, md.at);
                    chk("done_rob", done_rob, md.rob);
                    chk("done_rd", done_rd, md.rd);
                    chk("done_ex_b", ex_b, 32'd1);
                end
                hold_rob <= done_rob;
                hold_rd  <= done_rd;
            end else if (done_valid === 1'b1) begin
                chk("hold_rob", done_rob, hold_rob);
                chk("hold_rd", done_rd, hold_rd);
                chk("hold_ex_b", ex_b, 32'd1);
            end
            if (rs_free_valid === 1'b1) begin
                if (exp_free.size() == 0) begin
                    chk("free_unexpected", rs_free_valid, 32'd0);
                end else begin
                    mf = exp_free.pop_front();
                    chk("free_index", rs_free_index, mf);
                    chk("free_no_issue", issue_valid, 32'd0);
                    chk("free_done_low", done_valid, 32'd0);
                    chk("free_ex_b_low", ex_b, 32'd0);
                end
            end
            prev_done <= (done_valid === 1'b1);
        end else begin
            prev_done <= 1'b0;
        end
    end

    initial begin
        rst       = 1'b1;
        rs_ready  = 3'b000;
        rs_func   = 12'h000;
        rs_rob    = 9'd0;
        rs_rd     = 12'h000;
        cdb_grant = 1'b0;
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(2);

        // Single MUL on entry 0: rob 5, rd 3, grant on the first done cycle.
        rs_func  = 12'h002;
        rs_rob   = {3'd0, 3'd0, 3'd5};
        rs_rd    = {4'd0, 4'd0, 4'd3};
        exp_iss.push_back('{2'd0, 3'd5, 4'd3, 6});
        rs_ready = 3'b001;
        wait_issue();
        wait_done();
        exp_free.push_back(2'd0);
        grant(1'b1);
        step(5);

        // DIV on entry 1, grant delayed 4 cycles; RS fields change during EXEC.
        rs_func  = 12'h030;
        rs_rob   = {3'd0, 3'd2, 3'd0};
        rs_rd    = {4'd0, 4'd9, 4'd0};
        exp_iss.push_back('{2'd1, 3'd2, 4'd9, 8});
        rs_ready = 3'b010;
        wait_issue();
        rs_rob   = {3'd0, 3'd7, 3'd0};
        rs_rd    = {4'd0, 4'd1, 4'd0};
        wait_done();
        step(4);
        chk("div_held_valid", done_valid, 32'd1);
        chk("div_held_rob", done_rob, 32'd2);
        chk("div_held_rd", done_rd, 32'd9);
        exp_free.push_back(2'd1);
        grant(1'b1);
        step(3);

        // Ready entries with non mul/div funcs are never selected.
        rs_func  = 12'hF30;
        rs_ready = 3'b101;
        n0       = n_issue;
        step(10);
        chk("bad_func_ex_b", ex_b, 32'd0);
        chk("bad_func_issue", issue_valid, 32'd0);
        chk("bad_func_count", n_issue, n0);
        rs_ready = 3'b000;
        step(2);

        // MUL on entry 2, reset three cycles after issue with a grant present.
        rs_func  = 12'h200;
        rs_rob   = {3'd6, 3'd0, 3'd0};
        rs_rd    = {4'd10, 4'd0, 4'd0};
        exp_iss.push_back('{2'd2, 3'd6, 4'd10, 6});
        rs_ready = 3'b100;
        wait_issue();
        rs_ready = 3'b000;
        step(3);
        rst       = 1'b1;
        cdb_grant = 1'b1;
        exp_done.delete();
        step(1);
        rst       = 1'b0;
        cdb_grant = 1'b0;
        chk_all_zero("abort");
        step(12);
        chk("abort_no_done", done_valid, 32'd0);
        chk("abort_no_free", rs_free_valid, 32'd0);

        // All three MUL entries ready: round-robin 0,1,2,0 from the reset pointer.
        rs_func = 12'h222;
        rs_rob  = {3'd3, 3'd2, 3'd1};
        rs_rd   = {4'd6, 4'd5, 4'd4};
        for (int j = 0; j < 4; j++) begin
            exp_iss.push_back('{ord[j], 3'(ord[j] + 2'd1), 4'(ord[j] + 3'd4), 6});
        end
        rs_ready = 3'b111;
        for (int j = 0; j < 4; j++) begin
            if (j == 0) begin
                wait_issue();
                step(2);
                cdb_grant = 1'b1;
                step(1);
                cdb_grant = 1'b0;
            end
            wait_done();
            exp_free.push_back(ord[j]);
            grant(j == 3);
        end
        step(4);
        chk("rr_issues_drained", exp_iss.size(), 32'd0);
        chk("rr_frees_drained", exp_free.size(), 32'd0);
        chk("final_ex_b", ex_b, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
